// File: rtl/db_ram_arb_if.sv
// rtl/db_ram_arb_if.sv - request, RAM and response bundle between the requesters, the arbiter and the RAM
interface db_ram_arb_if #(
  parameter int RAM_ADDR   = 10,
  parameter int RAM_DWIDTH = 128
);
  logic                  a_valid;
  logic                  a_ready;
  logic                  a_we;
  logic [RAM_ADDR-1:0]   a_addr;
  logic [RAM_DWIDTH-1:0] a_wdata;
  logic                  b_valid;
  logic                  b_ready;
  logic                  b_we;
  logic [RAM_ADDR-1:0]   b_addr;
  logic [RAM_DWIDTH-1:0] b_wdata;
  logic                  ram_en;
  logic                  ram_we;
  logic [RAM_ADDR-1:0]   ram_addr;
  logic [RAM_DWIDTH-1:0] ram_din;
  logic [RAM_DWIDTH-1:0] ram_dout;
  logic                  a_rsp_valid;
  logic                  b_rsp_valid;
  logic [RAM_DWIDTH-1:0] rsp_data;

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    input  b_valid, b_we, b_addr, b_wdata,
    input  ram_dout,
    output a_ready, b_ready,
    output ram_en, ram_we, ram_addr, ram_din,
    output a_rsp_valid, b_rsp_valid, rsp_data
  );

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    output b_valid, b_we, b_addr, b_wdata,
    output ram_dout,
    input  a_ready, b_ready,
    input  ram_en, ram_we, ram_addr, ram_din,
    input  a_rsp_valid, b_rsp_valid, rsp_data
  );
endinterface

// File: rtl/db_ram_arb.sv
// rtl/db_ram_arb.sv - two-requester hash-table RAM arbiter with starvation guard for B
// Grant counters are built only when DB_RAM_ARB_STAT_EN is defined.
module db_ram_arb #(
  parameter int RAM_ADDR   = 10,
  parameter int RAM_DWIDTH = 128,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic         clk156,
  input  logic         rst,
  db_ram_arb_if.slave  bus,
  output logic [31:0]  stat_a_cnt,
  output logic [31:0]  stat_b_cnt
);

  logic [7:0]            starve_q, starve_d;
  logic                  grant_a, grant_b, acc;
  logic                  cmd_we;
  logic [RAM_ADDR-1:0]   cmd_addr;
  logic [RAM_DWIDTH-1:0] cmd_wdata;

  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic [RAM_ADDR-1:0]   addr_q, addr_d;
  logic [RAM_DWIDTH-1:0] din_q, din_d;
  logic [RAM_LAT:0]      trk_vld_q, trk_vld_d;
  logic [RAM_LAT:0]      trk_id_q, trk_id_d;
  logic                  rsp_a_q, rsp_a_d;
  logic                  rsp_b_q, rsp_b_d;
  logic [RAM_DWIDTH-1:0] rsp_data_q, rsp_data_d;

  // B wins only when A has monopolised the RAM for STARVE_MAX grants or A is idle
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (bus.b_valid && (starve_q == 8'(STARVE_MAX) || !bus.a_valid)) begin
        grant_b = 1'b1;
      end else if (bus.a_valid) begin
        grant_a = 1'b1;
      end
    end
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;
  assign acc         = grant_a | grant_b;
  assign cmd_we      = grant_b ? bus.b_we    : bus.a_we;
  assign cmd_addr    = grant_b ? bus.b_addr  : bus.a_addr;
  assign cmd_wdata   = grant_b ? bus.b_wdata : bus.a_wdata;

  always_comb begin
    starve_d = starve_q;
    if (!bus.b_valid || grant_b) begin
      starve_d = 8'd0;
    end else if (grant_a && starve_q != 8'(STARVE_MAX)) begin
      starve_d = starve_q + 8'd1;
    end

    en_d   = acc;
    we_d   = we_q;
    addr_d = addr_q;
    din_d  = din_q;
    if (acc) begin
      we_d   = cmd_we;
      addr_d = cmd_addr;
      din_d  = cmd_wdata;
    end

    // Each stage tags one RAM read; the last stage lines up with valid ram_dout
    trk_vld_d  = {trk_vld_q[RAM_LAT-1:0], acc & ~cmd_we};
    trk_id_d   = {trk_id_q[RAM_LAT-1:0], grant_b};
    rsp_a_d    = trk_vld_q[RAM_LAT] & ~trk_id_q[RAM_LAT];
    rsp_b_d    = trk_vld_q[RAM_LAT] & trk_id_q[RAM_LAT];
    rsp_data_d = trk_vld_q[RAM_LAT] ? bus.ram_dout : rsp_data_q;
  end

  always_ff @(posedge clk156) begin
    if (rst) begin
      starve_q   <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      trk_vld_q  <= '0;
      trk_id_q   <= '0;
      rsp_a_q    <= 1'b0;
      rsp_b_q    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      starve_q   <= starve_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      trk_vld_q  <= trk_vld_d;
      trk_id_q   <= trk_id_d;
      rsp_a_q    <= rsp_a_d;
      rsp_b_q    <= rsp_b_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.ram_en      = en_q;
  assign bus.ram_we      = we_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_din     = din_q;
  assign bus.a_rsp_valid = rsp_a_q;
  assign bus.b_rsp_valid = rsp_b_q;
  assign bus.rsp_data    = rsp_data_q;

`ifdef DB_RAM_ARB_STAT_EN
  logic [31:0] stat_a_q, stat_a_d;
  logic [31:0] stat_b_q, stat_b_d;

  always_comb begin
    stat_a_d = stat_a_q;
    stat_b_d = stat_b_q;
    if (grant_a && stat_a_q != 32'hFFFF_FFFF) stat_a_d = stat_a_q + 32'd1;
    if (grant_b && stat_b_q != 32'hFFFF_FFFF) stat_b_d = stat_b_q + 32'd1;
  end

  always_ff @(posedge clk156) begin
    if (rst) begin
      stat_a_q <= '0;
      stat_b_q <= '0;
    end else begin
      stat_a_q <= stat_a_d;
      stat_b_q <= stat_b_d;
    end
  end

  assign stat_a_cnt = stat_a_q;
  assign stat_b_cnt = stat_b_q;
`else
  assign stat_a_cnt = 32'd0;
  assign stat_b_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_db_ram_arb.sv
// tb/tb_db_ram_arb.sv - bench for db_ram_arb: RAM_LAT=1 and RAM_LAT=3 instances driven by shared stimulus
`timescale 1ns/1ps
module tb_db_ram_arb;
  localparam int AW = 10;
  localparam int DW = 128;
  localparam int SM = 8;
`ifdef DB_RAM_ARB_STAT_EN
  localparam int EXP_A = 100;
  localparam int EXP_B = 37;
`else
  localparam int EXP_A = 0;
  localparam int EXP_B = 0;
`endif

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  int cyc = 0;
  always @(posedge clk156) cyc <= cyc + 1;

  logic          rst;
  logic          a_valid, a_we, b_valid, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  int errors = 0;
  int checks = 0;

  db_ram_arb_if #(.RAM_ADDR(AW), .RAM_DWIDTH(DW)) bus0 ();
  db_ram_arb_if #(.RAM_ADDR(AW), .RAM_DWIDTH(DW)) bus1 ();

  logic [31:0] sa [2];
  logic [31:0] sb [2];

  db_ram_arb #(.RAM_ADDR(AW), .RAM_DWIDTH(DW), .RAM_LAT(1), .STARVE_MAX(SM)) u0 (
    .clk156(clk156), .rst(rst), .bus(bus0.slave), .stat_a_cnt(sa[0]), .stat_b_cnt(sb[0]));
  db_ram_arb #(.RAM_ADDR(AW), .RAM_DWIDTH(DW), .RAM_LAT(3), .STARVE_MAX(SM)) u1 (
    .clk156(clk156), .rst(rst), .bus(bus1.slave), .stat_a_cnt(sa[1]), .stat_b_cnt(sb[1]));

  assign bus0.a_valid = a_valid;  assign bus1.a_valid = a_valid;
  assign bus0.a_we    = a_we;     assign bus1.a_we    = a_we;
  assign bus0.a_addr  = a_addr;   assign bus1.a_addr  = a_addr;
  assign bus0.a_wdata = a_wdata;  assign bus1.a_wdata = a_wdata;
  assign bus0.b_valid = b_valid;  assign bus1.b_valid = b_valid;
  assign bus0.b_we    = b_we;     assign bus1.b_we    = b_we;
  assign bus0.b_addr  = b_addr;   assign bus1.b_addr  = b_addr;
  assign bus0.b_wdata = b_wdata;  assign bus1.b_wdata = b_wdata;

  logic [1:0]    ar, br, en, we, arv, brv;
  logic [AW-1:0] ad [2];
  logic [DW-1:0] din [2];
  logic [DW-1:0] rd [2];
  assign ar  = {bus1.a_ready, bus0.a_ready};
  assign br  = {bus1.b_ready, bus0.b_ready};
  assign en  = {bus1.ram_en, bus0.ram_en};
  assign we  = {bus1.ram_we, bus0.ram_we};
  assign arv = {bus1.a_rsp_valid, bus0.a_rsp_valid};
  assign brv = {bus1.b_rsp_valid, bus0.b_rsp_valid};
  assign ad[0] = bus0.ram_addr;   assign ad[1] = bus1.ram_addr;
  assign din[0] = bus0.ram_din;   assign din[1] = bus1.ram_din;
  assign rd[0] = bus0.rsp_data;   assign rd[1] = bus1.rsp_data;

  function automatic logic [DW-1:0] word(int i);
    return {32'(i), ~32'(i), 32'(i * 3 + 1), 32'hC0DE_0000 | 32'(i)};
  endfunction

  // RAM models: contents return to word(i) on every reset
  logic [DW-1:0] mem0 [1<<AW];
  logic [DW-1:0] mem1 [1<<AW];
  logic [DW-1:0] p0;
  logic [DW-1:0] p1 [3];
  always @(posedge clk156) begin
    if (rst) begin
      for (int k = 0; k < (1<<AW); k++) mem0[k] <= word(k);
      p0 <= '0;
    end else if (bus0.ram_en) begin
      if (bus0.ram_we) mem0[bus0.ram_addr] <= bus0.ram_din;
      else p0 <= mem0[bus0.ram_addr];
    end
  end
  always @(posedge clk156) begin
    if (rst) begin
      for (int k = 0; k < (1<<AW); k++) mem1[k] <= word(k);
      p1[0] <= '0; p1[1] <= '0; p1[2] <= '0;
    end else begin
      if (bus1.ram_en) begin
        if (bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_din;
        else p1[0] <= mem1[bus1.ram_addr];
      end
      p1[1] <= p1[0];
      p1[2] <= p1[1];
    end
  end
  assign bus0.ram_dout = p0;
  assign bus1.ram_dout = p1[2];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, req, cyc);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle
  logic [DW-1:0] tbm [1<<AW];
  exp_t          sbq [2][$];
  exp_t          e;
  int            starve_m;
  logic          g_a, g_b, m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_rd [2];

  always @(negedge clk156) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin sbq[i].delete(); m_rd[i] = '0; end
      for (int k = 0; k < (1<<AW); k++) tbm[k] = word(k);
      starve_m = 0; m_en = 0; m_we = 0; m_addr = '0; m_din = '0;
    end else begin
      g_b = b_valid && (starve_m == SM || !a_valid);
      g_a = a_valid && !g_b;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d_a_ready", i), ar[i], g_a);
        chk($sformatf("u%0d_b_ready", i), br[i], g_b);
        chk($sformatf("u%0d_ram_en", i), en[i], m_en);
        chk($sformatf("u%0d_ram_we", i), we[i], m_we);
        chk($sformatf("u%0d_ram_addr", i), ad[i], m_addr);
        chk($sformatf("u%0d_ram_din", i), din[i], m_din);
        if (sbq[i].size() > 0 && sbq[i][0].due <= cyc) begin
          e = sbq[i].pop_front();
          chk($sformatf("u%0d_a_rsp_valid", i), arv[i], !e.id);
          chk($sformatf("u%0d_b_rsp_valid", i), brv[i], e.id);
          chk($sformatf("u%0d_rsp_data", i), rd[i], e.data);
          m_rd[i] = e.data;
        end else begin
          chk($sformatf("u%0d_a_rsp_idle", i), arv[i], 1'b0);
          chk($sformatf("u%0d_b_rsp_idle", i), brv[i], 1'b0);
          chk($sformatf("u%0d_rsp_hold", i), rd[i], m_rd[i]);
        end
      end
      m_en = g_a || g_b;
      if (m_en) begin
        m_we   = g_b ? b_we : a_we;
        m_addr = g_b ? b_addr : a_addr;
        m_din  = g_b ? b_wdata : a_wdata;
        if (m_we) tbm[m_addr] = m_din;
        else for (int i = 0; i < 2; i++) sbq[i].push_back('{g_b, tbm[m_addr], cyc + 3 + 2 * i});
      end
      if (!b_valid || g_b) starve_m = 0;
      else if (g_a && starve_m < SM) starve_m++;
    end
  end

  task automatic step();
    @(posedge clk156);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; a_we = 0; b_we = 0;
  endtask

  int   run, maxrun, nrsp;
  int   s4_acc [$];
  logic s4_aid [$];
  int   s4_rsp [$];
  logic s4_rid [$];

  initial begin
    rst = 1; idle();
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    a_valid = 1; b_valid = 1;
    repeat (3) step();
    @(negedge clk156);
    for (int i = 0; i < 2; i++) begin
      chk("rst_a_ready", ar[i], 0);       chk("rst_b_ready", br[i], 0);
      chk("rst_ram_en", en[i], 0);        chk("rst_ram_we", we[i], 0);
      chk("rst_ram_addr", ad[i], 0);      chk("rst_ram_din", din[i], 0);
      chk("rst_a_rsp", arv[i], 0);        chk("rst_b_rsp", brv[i], 0);
      chk("rst_rsp_data", rd[i], 0);
      chk("rst_stat_a", sa[i], 0);        chk("rst_stat_b", sb[i], 0);
    end
    step(); rst = 0; idle();

    // A-only read of address 5 accepted in cycle 10
    while (cyc < 10) step();
    a_valid = 1; a_we = 0; a_addr = 10'h005;
    step(); idle();
    @(negedge clk156);
    chk("s1_ram_en", en[0], 1);
    chk("s1_ram_addr", ad[0], 10'h005);
    step(); step();
    @(negedge clk156);
    chk("s1_cycle", cyc, 13);
    chk("s1_a_rsp", arv[0], 1);
    chk("s1_data", rd[0], word(5));
    repeat (8) step();

    // Both requesters saturated: 8 A grants then 1 B grant
    a_valid = 1; b_valid = 1; run = 0; maxrun = 0;
    for (int k = 0; k < 20; k++) begin
      a_addr = 10'(k); b_addr = 10'(100 + k);
      @(negedge clk156);
      chk("s2_grant_b", br[0], (k % 9) == 8);
      chk("s2_grant_a", ar[0], (k % 9) != 8);
      if (ar[0]) run++; else run = 0;
      if (run > maxrun) maxrun = run;
      step();
    end
    idle();
    chk("s2_maxrun", maxrun, SM);
    repeat (8) step();

    // Write 0xAB to 0x3FF, read it back the next cycle
    a_valid = 1; a_we = 1; a_addr = 10'h3FF; a_wdata = 128'hAB;
    step(); a_we = 0;
    @(negedge clk156);
    chk("s3_en_wr", en[0], 1);
    chk("s3_we_1", we[0], 1);
    step(); idle();
    @(negedge clk156);
    chk("s3_en_rd", en[0], 1);
    chk("s3_we_0", we[0], 0);
    nrsp = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      @(negedge clk156);
      if (arv[0]) begin nrsp++; chk("s3_data", rd[0], 128'hAB); end
    end
    chk("s3_nrsp", nrsp, 1);
    repeat (4) step();

    // Alternating A/B reads every cycle; latency and tagging on the RAM_LAT=3 instance
    for (int k = 0; k < 20; k++) begin
      if (k < 8) begin
        a_valid = (k % 2) == 0; b_valid = (k % 2) == 1;
        a_addr = 10'(k * 7); b_addr = 10'(k * 11 + 3);
      end else idle();
      @(negedge clk156);
      if (ar[1] || br[1]) begin s4_acc.push_back(cyc); s4_aid.push_back(br[1]); end
      if (arv[1] || brv[1]) begin s4_rsp.push_back(cyc); s4_rid.push_back(brv[1]); end
      step();
    end
    chk("s4_accepts", s4_acc.size(), 8);
    chk("s4_responses", s4_rsp.size(), 8);
    for (int j = 0; j < s4_rsp.size() && j < s4_acc.size(); j++) begin
      chk($sformatf("s4_lat%0d", j), s4_rsp[j] - s4_acc[j], 5);
      chk($sformatf("s4_id%0d", j), s4_rid[j], s4_aid[j]);
      chk($sformatf("s4_order%0d", j), s4_rid[j], (j % 2) == 1);
    end
    repeat (4) step();

    // Reset one cycle after two reads are accepted
    a_valid = 1; a_addr = 10'h001;
    step(); a_addr = 10'h002;
    step(); idle(); rst = 1; a_valid = 1;
    @(negedge clk156);
    chk("s5_a_ready_rst", ar[0], 0);
    chk("s5_a_ready_rst_u1", ar[1], 0);
    step(); rst = 0; idle();
    @(negedge clk156);
    for (int i = 0; i < 2; i++) begin
      chk("s5_ram_en", en[i], 0);     chk("s5_ram_we", we[i], 0);
      chk("s5_ram_addr", ad[i], 0);   chk("s5_ram_din", din[i], 0);
      chk("s5_rsp_data", rd[i], 0);
    end
    nrsp = 0;
    for (int k = 0; k < 8; k++) begin
      if (arv != 0 || brv != 0) nrsp++;
      step();
      @(negedge clk156);
    end
    chk("s5_no_rsp", nrsp, 0);

    // Grant counters: 100 A then 37 B accepts after a fresh reset
    rst = 1; step(); rst = 0;
    @(negedge clk156);
    chk("s6_stat_a_clr", sa[0], 0);
    chk("s6_stat_b_clr", sb[0], 0);
    step();
    a_valid = 1;
    for (int k = 0; k < 100; k++) begin a_addr = 10'(k); step(); end
    a_valid = 0; b_valid = 1;
    for (int k = 0; k < 37; k++) begin b_addr = 10'(500 + k); step(); end
    idle();
    repeat (8) step();
    @(negedge clk156);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_stat_a", i), sa[i], EXP_A);
      chk($sformatf("u%0d_stat_b", i), sb[i], EXP_B);
      chk($sformatf("u%0d_drained", i), sbq[i].size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
